// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with a divide-by-zero shortcut straight to DONE.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             load, step, finish, zero_finish;

  // One restoring iteration on {R, Q}; Q starts as the dividend so its MSB
  // feeds R while the new quotient bit enters at the LSB.
  function automatic logic [2*WIDTH-1:0] restore_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvs
  );
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    if (!trial[WIDTH])
      return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    else
      return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  assign {rem_nxt, quo_nxt} = restore_step(rem_q, quo_q, dvs_q);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    step        = 1'b0;
    finish      = 1'b0;
    zero_finish = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (divisor == '0) begin
            state_nxt   = DONE;
            zero_finish = 1'b1;
          end else begin
            state_nxt = RUN;
            load      = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == '0) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers: cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cnt         <= CNT_W'(WIDTH - 1);
        div_by_zero <= 1'b0;
      end else if (zero_finish) begin
        cnt         <= '0;
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else if (finish) begin
        quotient  <= quo_nxt;
        remainder <= rem_nxt;
      end else if (step) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Working datapath: only meaningful between load and finish, so no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table, handshake corner cases and an
// exhaustive 4-bit sweep against a behavioural divide model.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: raise start with operands, drop it one cycle later.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // lat counts negedges since the accepting edge; returns on done or timeout.
  task automatic wait_done(input int lat0, output int lat, output int bcnt);
    lat  = lat0;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[14];
  int   lat, bcnt, extra;

  initial begin
    vecs[0]  = '{a: 6,  b: 2,  q: 3,  r: 0, z: 0};
    vecs[1]  = '{a: 15, b: 4,  q: 3,  r: 3, z: 0};
    vecs[2]  = '{a: 2,  b: 3,  q: 0,  r: 2, z: 0};
    vecs[3]  = '{a: 7,  b: 0,  q: 15, r: 7, z: 1};
    vecs[4]  = '{a: 9,  b: 3,  q: 3,  r: 0, z: 0};
    vecs[5]  = '{a: 12, b: 5,  q: 2,  r: 2, z: 0};
    vecs[6]  = '{a: 13, b: 2,  q: 6,  r: 1, z: 0};
    vecs[7]  = '{a: 0,  b: 1,  q: 0,  r: 0, z: 0};
    vecs[8]  = '{a: 15, b: 1,  q: 15, r: 0, z: 0};
    vecs[9]  = '{a: 15, b: 15, q: 1,  r: 0, z: 0};
    vecs[10] = '{a: 1,  b: 15, q: 0,  r: 1, z: 0};
    vecs[11] = '{a: 0,  b: 0,  q: 15, r: 0, z: 1};
    vecs[12] = '{a: 14, b: 3,  q: 4,  r: 2, z: 0};
    vecs[13] = '{a: 8,  b: 7,  q: 1,  r: 1, z: 0};

    // Reset state
    #12;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(1, lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, (vecs[i].b == 0) ? 1 : W + 1);
      check($sformatf("v%0d_busy_cycles", i), bcnt, (vecs[i].b == 0) ? 0 : W);
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d_dbz", i), div_by_zero, vecs[i].z);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_hold_q", i), quotient, vecs[i].q);
    end

    // Back-to-back: second start issued in the DONE cycle
    issue(15, 4);
    wait_done(1, lat, bcnt);
    check("b2b_first_q", quotient, 3);
    check("b2b_first_r", remainder, 3);
    issue(2, 3);
    check("b2b_accept_busy", busy, 1);
    check("b2b_accept_done", done, 0);
    check("b2b_hold_q_in_run", quotient, 3);
    check("b2b_hold_r_in_run", remainder, 3);
    wait_done(1, lat, bcnt);
    check("b2b_latency", lat, W + 1);
    check("b2b_second_q", quotient, 0);
    check("b2b_second_r", remainder, 2);
    @(negedge clk);

    // Start while busy is ignored
    issue(12, 5);
    @(negedge clk);
    dividend = 9;
    divisor  = 3;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(3, lat, bcnt);
    check("ign_latency", lat, W + 1);
    check("ign_q", quotient, 2);
    check("ign_r", remainder, 2);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("ign_extra_done", extra, 0);
    check("ign_idle_busy", busy, 0);

    // Asynchronous reset mid-RUN
    issue(13, 2);
    check("arst_pre_busy", busy, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(13, 2);
    wait_done(1, lat, bcnt);
    check("arst_rerun_latency", lat, W + 1);
    check("arst_rerun_q", quotient, 6);
    check("arst_rerun_r", remainder, 1);
    @(negedge clk);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int eq, er;
        eq = (b == 0) ? 15 : a / b;
        er = (b == 0) ? a : a % b;
        issue(W'(a), W'(b));
        wait_done(1, lat, bcnt);
        check($sformatf("sw_%0d_%0d_q", a, b), quotient, eq);
        check($sformatf("sw_%0d_%0d_r", a, b), remainder, er);
        check($sformatf("sw_%0d_%0d_dbz", a, b), div_by_zero, (b == 0) ? 1 : 0);
        if (b != 0)
          check($sformatf("sw_%0d_%0d_inv", a, b),
                ((int'(quotient) * b + int'(remainder)) == a && int'(remainder) < b) ? 1 : 0, 1);
        @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
